// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: request opcodes, CSR numbers,
// reset values and the masked-exchange helper.
package csr_access_unit_pkg;

    // Request opcodes; encodings 5..7 are executed as reads.
    typedef enum logic [2:0] {
        OP_RD   = 3'd0,
        OP_WR   = 3'd1,
        OP_XCHG = 3'd2,
        OP_LL   = 3'd3,
        OP_SC   = 3'd4
    } req_op_t;

    // Response channel state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } resp_state_t;

    // CSR numbers.
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;
    localparam logic [13:0] CSR_LLBCTL = 14'h060;

    // CRMD field positions: PLV[1:0], IE[2], DA[3], PG[4].
    localparam int CRMD_IE_BIT     = 2;
    localparam logic [4:0] CRMD_RESET = 5'h08;

    // LLBCTL field positions.
    localparam int LLBCTL_WCLLB_BIT = 1;
    localparam int LLBCTL_KLO_BIT   = 2;

    // XCHG: bits selected by mask come from wdata, the rest keep the old value.
    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [31:0] mask);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/csr_access_unit_timer.sv
// Stable timer: holds TCFG and the TVAL down-counter and flags the cycle on
// which an armed, enabled count reaches zero. Only built with CSR_TIMER_EN.
module csr_access_unit_timer
    import csr_access_unit_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               fire
);

    logic armed;
    logic en;
    logic periodic;

    assign en       = tcfg[0];
    assign periodic = tcfg[1];

    // Fires while the counter sits at zero; the owner sets IS[11] on this edge.
    assign fire = armed & en & (tval == '0);

    // TCFG write loads {InitVal,2'b00} and re-arms; otherwise count down while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcfg  <= '0;
            tval  <= '0;
            armed <= 1'b0;
        end else if (tcfg_we) begin
            tcfg  <= tcfg_wdata;
            tval  <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
            armed <= 1'b1;
        end else if (armed && en) begin
            if (tval == '0) begin
                if (periodic) begin
                    tval <= {tcfg[TIMER_W-1:2], 2'b00};
                end else begin
                    armed <= 1'b0;
                end
            end else begin
                tval <= tval - TIMER_W'(1);
            end
        end
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: executes CSRRD/CSRWR/CSRXCHG/LL.W/SC.W with a one-deep
// response register, owns the architectural CSRs and the LLbit, and applies
// exception entry / ERTN updates from commit.
// Optional stable timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built when the
// macro CSR_TIMER_EN is defined; otherwise those CSRs read 0 and IS[11] stays 0.
//
// Handshake: a request transfers on a clock edge where req_valid && req_ready;
// a response transfers where resp_valid && resp_ready. req_ready is high when
// the response slot is empty or being drained this cycle, so with resp_ready
// held high one request is accepted and answered per cycle. While stalled,
// resp_* do not change.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          TIMER_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [13:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_mask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_sc_ok,
    input  logic        excp_valid,
    input  logic [5:0]  excp_ecode,
    input  logic [31:0] excp_pc,
    input  logic        ertn_valid,
    output logic [31:0] era_out,
    output logic        irq_pending
);

    // Architectural state.
    logic [4:0]  crmd;
    logic [2:0]  prmd;
    logic [1:0]  estat_is;
    logic        estat_is11;
    logic [5:0]  estat_ecode;
    logic [31:0] era;
    logic [31:0] save [4];
    logic [31:0] tid;
    logic        llbit;
    logic        klo;

    resp_state_t state;

    // Timer view.
    logic [TIMER_W-1:0] tcfg_val;
    logic [TIMER_W-1:0] tval_val;
    logic               timer_fire;

    // Request decode.
    logic        accept;
    logic        is_wr;
    logic        is_xchg;
    logic        is_ll;
    logic        is_sc;
    logic        wr_en;
    logic [31:0] rd_val;
    logic [31:0] new_val;

    logic sel_crmd;
    logic sel_prmd;
    logic sel_estat;
    logic sel_era;
    logic sel_save;
    logic sel_tid;
    logic sel_llbctl;
    logic ticlr_clr;
    logic wcllb_clr;

    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    assign is_wr   = (req_op == OP_WR);
    assign is_xchg = (req_op == OP_XCHG);
    assign is_ll   = (req_op == OP_LL);
    assign is_sc   = (req_op == OP_SC);
    assign wr_en   = accept && (is_wr || is_xchg);

    // Pre-edge read value of the addressed CSR; unlisted numbers and bits read 0.
    always_comb begin
        rd_val = 32'h0;
        case (req_addr)
            CSR_CRMD:   rd_val = {27'h0, crmd};
            CSR_PRMD:   rd_val = {29'h0, prmd};
            CSR_ESTAT:  rd_val = {10'h0, estat_ecode, 4'h0, estat_is11, 9'h0, estat_is};
            CSR_ERA:    rd_val = era;
            CSR_SAVE0:  rd_val = save[0];
            CSR_SAVE1:  rd_val = save[1];
            CSR_SAVE2:  rd_val = save[2];
            CSR_SAVE3:  rd_val = save[3];
            CSR_TID:    rd_val = tid;
            CSR_TCFG:   rd_val = 32'(tcfg_val);
            CSR_TVAL:   rd_val = 32'(tval_val);
            CSR_LLBCTL: rd_val = {29'h0, klo, 1'b0, llbit};
            default:    rd_val = 32'h0;
        endcase
    end

    // Value to be written: plain write or masked exchange against the old value.
    always_comb begin
        new_val = req_wdata;
        if (is_xchg) begin
            new_val = csr_merge(rd_val, req_wdata, req_mask);
        end
    end

    assign sel_crmd   = wr_en && (req_addr == CSR_CRMD);
    assign sel_prmd   = wr_en && (req_addr == CSR_PRMD);
    assign sel_estat  = wr_en && (req_addr == CSR_ESTAT);
    assign sel_era    = wr_en && (req_addr == CSR_ERA);
    assign sel_save   = wr_en && (req_addr[13:2] == CSR_SAVE0[13:2]);
    assign sel_tid    = wr_en && (req_addr == CSR_TID);
    assign sel_llbctl = wr_en && (req_addr == CSR_LLBCTL);
    assign ticlr_clr  = wr_en && (req_addr == CSR_TICLR) && new_val[0];
    assign wcllb_clr  = sel_llbctl && new_val[LLBCTL_WCLLB_BIT];

`ifdef CSR_TIMER_EN
    logic tcfg_we;
    assign tcfg_we = wr_en && (req_addr == CSR_TCFG);

    csr_access_unit_timer #(
        .TIMER_W(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .tcfg_we   (tcfg_we),
        .tcfg_wdata(new_val[TIMER_W-1:0]),
        .tcfg      (tcfg_val),
        .tval      (tval_val),
        .fire      (timer_fire)
    );
`else
    assign tcfg_val   = '0;
    assign tval_val   = '0;
    assign timer_fire = 1'b0;
`endif

    // CRMD/PRMD/ERA/ESTAT: exception entry beats ERTN beats the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crmd        <= CRMD_RESET;
            prmd        <= 3'h0;
            era         <= 32'h0;
            estat_is    <= 2'h0;
            estat_is11  <= 1'b0;
            estat_ecode <= 6'h0;
        end else begin
            if (excp_valid) begin
                crmd[2:0] <= 3'h0;
            end else if (ertn_valid) begin
                crmd[2:0] <= prmd;
            end else if (sel_crmd) begin
                crmd[2:0] <= new_val[2:0];
            end
            if (sel_crmd) begin
                crmd[4:3] <= new_val[4:3];
            end

            if (excp_valid) begin
                prmd <= crmd[2:0];
            end else if (sel_prmd) begin
                prmd <= new_val[2:0];
            end

            if (excp_valid) begin
                era <= excp_pc;
            end else if (sel_era) begin
                era <= new_val;
            end

            if (excp_valid) begin
                estat_ecode <= excp_ecode;
            end

            if (sel_estat) begin
                estat_is <= new_val[1:0];
            end

            // A timer expiry on the same edge as a TICLR write leaves IS[11] set.
            if (timer_fire) begin
                estat_is11 <= 1'b1;
            end else if (ticlr_clr) begin
                estat_is11 <= 1'b0;
            end
        end
    end

    // Scratch registers and TID: written only by requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                save[i] <= 32'h0;
            end
            tid <= TID_RESET;
        end else begin
            if (sel_save) begin
                save[req_addr[1:0]] <= new_val;
            end
            if (sel_tid) begin
                tid <= new_val;
            end
        end
    end

    // LLbit and KLO: ERTN consumes KLO if set, otherwise clears LLbit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llbit <= 1'b0;
            klo   <= 1'b0;
        end else begin
            if (ertn_valid && !klo) begin
                llbit <= 1'b0;
            end else if (accept && is_ll) begin
                llbit <= 1'b1;
            end else if ((accept && is_sc) || wcllb_clr) begin
                llbit <= 1'b0;
            end

            if (ertn_valid && klo) begin
                klo <= 1'b0;
            end else if (sel_llbctl) begin
                klo <= new_val[LLBCTL_KLO_BIT];
            end
        end
    end

    // Response FSM: capture the pre-edge result on accept, hold until drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            resp_rdata <= 32'h0;
            resp_sc_ok <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_RESP;
                        resp_rdata <= (is_ll || is_sc) ? 32'h0 : rd_val;
                        resp_sc_ok <= is_sc && llbit;
                    end
                end
                ST_RESP: begin
                    if (accept) begin
                        state      <= ST_RESP;
                        resp_rdata <= (is_ll || is_sc) ? 32'h0 : rd_val;
                        resp_sc_ok <= is_sc && llbit;
                    end else if (resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid  = (state == ST_RESP);
    assign era_out     = era;
    assign irq_pending = crmd[CRMD_IE_BIT] && (estat_is11 || (|estat_is));

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: directed sequences with literal expectations
// plus a randomized phase, all checked every cycle against a field-level
// architectural model of the CSR file.
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'h0;
    logic [13:0] req_addr = 14'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_mask = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_sc_ok;
    logic        excp_valid = 1'b0;
    logic [5:0]  excp_ecode = 6'h0;
    logic [31:0] excp_pc = 32'h0;
    logic        ertn_valid = 1'b0;
    logic [31:0] era_out;
    logic        irq_pending;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1);
    end

    csr_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_sc_ok (resp_sc_ok),
        .excp_valid (excp_valid),
        .excp_ecode (excp_ecode),
        .excp_pc    (excp_pc),
        .ertn_valid (ertn_valid),
        .era_out    (era_out),
        .irq_pending(irq_pending)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    logic [4:0]  m_crmd;
    logic [2:0]  m_prmd;
    logic [1:0]  m_is;
    logic        m_is11;
    logic [5:0]  m_ecode;
    logic [31:0] m_era;
    logic [31:0] m_save [4];
    logic [31:0] m_tid;
    logic        m_llbit;
    logic        m_klo;
    logic [31:0] m_tcfg;
    logic [31:0] m_tval;
    logic        m_armed;

    // Expected responses: {sc_ok, rdata}; head is the one currently presented.
    logic [32:0] exp_q[$];

    task automatic m_reset();
        m_crmd  = 5'h08;
        m_prmd  = 3'h0;
        m_is    = 2'h0;
        m_is11  = 1'b0;
        m_ecode = 6'h0;
        m_era   = 32'h0;
        for (int i = 0; i < 4; i++) m_save[i] = 32'h0;
        m_tid   = 32'h0;
        m_llbit = 1'b0;
        m_klo   = 1'b0;
        m_tcfg  = 32'h0;
        m_tval  = 32'h0;
        m_armed = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] m_read(input logic [13:0] a);
        case (a)
            14'h000: return {27'h0, m_crmd};
            14'h001: return {29'h0, m_prmd};
            14'h005: return (32'(m_ecode) << 16) | (32'(m_is11) << 11) | 32'(m_is);
            14'h006: return m_era;
            14'h030, 14'h031, 14'h032, 14'h033: return m_save[a[1:0]];
            14'h040: return m_tid;
`ifdef CSR_TIMER_EN
            14'h041: return m_tcfg;
            14'h042: return m_tval;
`endif
            14'h060: return {29'h0, m_klo, 1'b0, m_llbit};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [13:0] a, input logic [31:0] v);
        case (a)
            14'h000: m_crmd = v[4:0];
            14'h001: m_prmd = v[2:0];
            14'h005: m_is = v[1:0];
            14'h006: m_era = v;
            14'h030, 14'h031, 14'h032, 14'h033: m_save[a[1:0]] = v;
            14'h040: m_tid = v;
`ifdef CSR_TIMER_EN
            14'h041: begin
                m_tcfg  = v;
                m_tval  = v & 32'hFFFF_FFFC;
                m_armed = 1'b1;
            end
            14'h044: if (v[0]) m_is11 = 1'b0;
`endif
            14'h060: begin
                if (v[1]) m_llbit = 1'b0;
                m_klo = v[2];
            end
            default: ;
        endcase
    endtask

    // One clock edge of architectural behaviour, from the pre-edge inputs.
    task automatic m_step();
        logic [4:0]  p_crmd;
        logic [2:0]  p_prmd;
        logic        p_klo;
        logic        p_llbit;
        logic        fire;
        logic        acc;
        logic [31:0] old;
        p_crmd  = m_crmd;
        p_prmd  = m_prmd;
        p_klo   = m_klo;
        p_llbit = m_llbit;
        acc = req_valid && (exp_q.size() == 0 || resp_ready);
        old = m_read(req_addr);
        if (exp_q.size() != 0 && resp_ready) void'(exp_q.pop_front());
        fire = 1'b0;
`ifdef CSR_TIMER_EN
        fire = m_armed && m_tcfg[0] && (m_tval == 32'h0);
        if (m_armed && m_tcfg[0]) begin
            if (m_tval == 32'h0) begin
                if (m_tcfg[1]) m_tval = m_tcfg & 32'hFFFF_FFFC;
                else m_armed = 1'b0;
            end else begin
                m_tval = m_tval - 1;
            end
        end
`endif
        if (acc) begin
            if (req_op == 3'd3) begin
                exp_q.push_back({1'b0, 32'h0});
                m_llbit = 1'b1;
            end else if (req_op == 3'd4) begin
                exp_q.push_back({p_llbit, 32'h0});
                m_llbit = 1'b0;
            end else begin
                exp_q.push_back({1'b0, old});
                if (req_op == 3'd1) m_write(req_addr, req_wdata);
                if (req_op == 3'd2) m_write(req_addr, (old & ~req_mask) | (req_wdata & req_mask));
            end
        end
        if (ertn_valid) begin
            m_crmd[2:0] = p_prmd;
            if (p_klo) m_klo = 1'b0;
            else m_llbit = 1'b0;
        end
        if (excp_valid) begin
            m_prmd      = p_crmd[2:0];
            m_crmd[2:0] = 3'h0;
            m_era       = excp_pc;
            m_ecode     = excp_ecode;
        end
        if (fire) m_is11 = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step();
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("req_ready", 32'(req_ready), 32'((exp_q.size() == 0) || resp_ready));
            check("resp_valid", 32'(resp_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0 && resp_valid) begin
                check("resp_rdata", resp_rdata, exp_q[0][31:0]);
                check("resp_sc_ok", 32'(resp_sc_ok), 32'(exp_q[0][32]));
            end
            check("era_out", era_out, m_era);
            check("irq_pending", 32'(irq_pending),
                  32'(m_crmd[2] && (m_is11 || (|m_is))));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with resp_ready=1; returns the response one cycle later.
    task automatic do_req(input logic [2:0] op, input logic [13:0] addr,
                          input logic [31:0] wd, input logic [31:0] mk,
                          output logic [31:0] rd, output logic sc);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wd;
        req_mask   = mk;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("latency1_valid", 32'(resp_valid), 32'h1);
        rd = resp_rdata;
        sc = resp_sc_ok;
        tick();
    endtask

    task automatic req_expect(input string name, input logic [2:0] op, input logic [13:0] addr,
                              input logic [31:0] wd, input logic [31:0] mk,
                              input logic [31:0] exp_rd);
        logic [31:0] rd;
        logic        sc;
        do_req(op, addr, wd, mk, rd, sc);
        check(name, rd, exp_rd);
    endtask

    task automatic sc_expect(input string name, input logic exp_ok);
        logic [31:0] rd;
        logic        sc;
        do_req(3'd4, 14'h0, 32'h0, 32'h0, rd, sc);
        check(name, 32'(sc), 32'(exp_ok));
        check({name, "_rdata"}, rd, 32'h0);
    endtask

    task automatic pulse_commit(input logic excp, input logic [5:0] ec,
                                input logic [31:0] pc, input logic ertn);
        excp_valid = excp;
        excp_ecode = ec;
        excp_pc    = pc;
        ertn_valid = ertn;
        tick();
        excp_valid = 1'b0;
        ertn_valid = 1'b0;
    endtask

    task automatic rand_phase(input int cycles);
        logic [13:0] addrs [13] = '{14'h000, 14'h001, 14'h005, 14'h006, 14'h030, 14'h031,
                                    14'h032, 14'h033, 14'h040, 14'h041, 14'h042, 14'h044,
                                    14'h060};
        int k;
        for (int i = 0; i < cycles; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_op     = 3'($urandom_range(0, 7));
            k          = $urandom_range(0, 14);
            req_addr   = (k < 13) ? addrs[k] : 14'($urandom);
            req_wdata  = $urandom;
            req_mask   = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            excp_valid = ($urandom_range(0, 19) == 0);
            excp_ecode = 6'($urandom);
            excp_pc    = $urandom;
            ertn_valid = ($urandom_range(0, 15) == 0);
            tick();
        end
        req_valid  = 1'b0;
        excp_valid = 1'b0;
        ertn_valid = 1'b0;
        resp_ready = 1'b1;
        repeat (3) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] held;
        int          c;
        bit          seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Reset state.
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_era", era_out, 32'h0);
        check("rst_irq", 32'(irq_pending), 32'h0);
        tick();
        req_expect("rd_crmd_reset", 3'd0, 14'h000, 32'h0, 32'h0, 32'h0000_0008);
        req_expect("rd_tid_reset", 3'd0, 14'h040, 32'h0, 32'h0, 32'h0);
        req_expect("rd_estat_reset", 3'd0, 14'h005, 32'h0, 32'h0, 32'h0);

        // Write and masked exchange on SAVE0.
        req_expect("wr_save0", 3'd1, 14'h030, 32'hDEAD_BEEF, 32'h0, 32'h0);
        req_expect("xchg_save0_a", 3'd2, 14'h030, 32'h0000_FFFF, 32'h00FF_00FF, 32'hDEAD_BEEF);
        req_expect("rd_save0_a", 3'd0, 14'h030, 32'h0, 32'h0, 32'hDE00_BEFF);
        req_expect("wr_save0_b", 3'd1, 14'h030, 32'hDEAD_BEEF, 32'h0, 32'hDE00_BEFF);
        req_expect("xchg_save0_b", 3'd2, 14'h030, 32'h00FF_00FF, 32'h0000_FFFF, 32'hDEAD_BEEF);
        req_expect("rd_save0_b", 3'd0, 14'h030, 32'h0, 32'h0, 32'hDEAD_00FF);
        req_expect("rd_unlisted", 3'd0, 14'h123, 32'h0, 32'h0, 32'h0);
        req_expect("op7_as_rd", 3'd7, 14'h030, 32'h1234, 32'hFFFF_FFFF, 32'hDEAD_00FF);

        // LL / SC and WCLLB.
        req_expect("ll_rdata", 3'd3, 14'h030, 32'h0, 32'h0, 32'h0);
        sc_expect("sc_after_ll", 1'b1);
        sc_expect("sc_again", 1'b0);
        req_expect("ll2_rdata", 3'd3, 14'h000, 32'h0, 32'h0, 32'h0);
        req_expect("rd_llbctl_set", 3'd0, 14'h060, 32'h0, 32'h0, 32'h1);
        req_expect("wr_llbctl_wcllb", 3'd1, 14'h060, 32'h2, 32'h0, 32'h1);
        req_expect("rd_llbctl_clr", 3'd0, 14'h060, 32'h0, 32'h0, 32'h0);
        sc_expect("sc_after_wcllb", 1'b0);

        // Back-pressure: response held, next request waits.
        req_valid  = 1'b1;
        req_op     = 3'd0;
        req_addr   = 14'h030;
        resp_ready = 1'b0;
        tick();
        req_op    = 3'd1;
        req_addr  = 14'h031;
        req_wdata = 32'h0000_1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req_ready", 32'(req_ready), 32'h0);
            check("stall_valid", 32'(resp_valid), 32'h1);
            check("stall_rdata", resp_rdata, 32'hDEAD_00FF);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("stall_next_rdata", resp_rdata, 32'h0);
        tick();
        @(negedge clk);
        check("stall_drained", 32'(resp_valid), 32'h0);
        tick();
        req_expect("rd_save1", 3'd0, 14'h031, 32'h0, 32'h0, 32'h0000_1234);

        // Exception entry and ERTN.
        req_expect("wr_crmd7", 3'd1, 14'h000, 32'h7, 32'h0, 32'h8);
        req_expect("ll3_rdata", 3'd3, 14'h000, 32'h0, 32'h0, 32'h0);
        pulse_commit(1'b1, 6'hB, 32'h1C00_0100, 1'b0);
        @(negedge clk);
        check("excp_era", era_out, 32'h1C00_0100);
        tick();
        req_expect("excp_prmd", 3'd0, 14'h001, 32'h0, 32'h0, 32'h7);
        req_expect("excp_crmd", 3'd0, 14'h000, 32'h0, 32'h0, 32'h0);
        req_expect("excp_estat", 3'd0, 14'h005, 32'h0, 32'h0, 32'h000B_0000);
        req_expect("excp_rd_era", 3'd0, 14'h006, 32'h0, 32'h0, 32'h1C00_0100);
        pulse_commit(1'b0, 6'h0, 32'h0, 1'b1);
        req_expect("ertn_crmd", 3'd0, 14'h000, 32'h0, 32'h0, 32'h7);
        sc_expect("sc_after_ertn", 1'b0);
        req_expect("wr_klo", 3'd1, 14'h060, 32'h4, 32'h0, 32'h0);
        req_expect("ll4_rdata", 3'd3, 14'h000, 32'h0, 32'h0, 32'h0);
        pulse_commit(1'b0, 6'h0, 32'h0, 1'b1);
        req_expect("klo_keeps_llbit", 3'd0, 14'h060, 32'h0, 32'h0, 32'h1);
        req_expect("wr_estat_is0", 3'd1, 14'h005, 32'h1, 32'h0, 32'h000B_0000);
        @(negedge clk);
        check("irq_on", 32'(irq_pending), 32'h1);
        tick();
        req_expect("wr_estat_clr", 3'd1, 14'h005, 32'h0, 32'h0, 32'h000B_0001);
        @(negedge clk);
        check("irq_off", 32'(irq_pending), 32'h0);
        tick();

`ifdef CSR_TIMER_EN
        // Periodic timer, InitVal=4: IS[11] appears 17 edges after the write.
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_addr  = 14'h041;
        req_wdata = 32'h13;
        tick();
        req_valid = 1'b0;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk);
            if (irq_pending) seen = 1'b1;
            else c++;
        end
        check("timer_fire_seen", 32'(seen), 32'h1);
        check("timer_fire_delay", 32'(c), 32'd17);
        tick();
        req_expect("ticlr_rdata", 3'd1, 14'h044, 32'h1, 32'h0, 32'h0);
        @(negedge clk);
        check("ticlr_irq_off", 32'(irq_pending), 32'h0);
        tick();
        req_expect("rd_tcfg", 3'd0, 14'h041, 32'h0, 32'h0, 32'h13);
        req_expect("wr_tcfg_off", 3'd1, 14'h041, 32'h0, 32'h0, 32'h13);
`else
        req_expect("wr_tcfg_drop", 3'd1, 14'h041, 32'h13, 32'h0, 32'h0);
        req_expect("rd_tcfg_zero", 3'd0, 14'h041, 32'h0, 32'h0, 32'h0);
        repeat (20) tick();
        @(negedge clk);
        check("no_timer_irq", 32'(irq_pending), 32'h0);
        tick();
        req_expect("rd_tval_zero", 3'd0, 14'h042, 32'h0, 32'h0, 32'h0);
`endif

        // Randomized traffic checked against the model every cycle.
        rand_phase(3000);

        // Reset while a response is held drops it.
        req_valid  = 1'b1;
        req_op     = 3'd0;
        req_addr   = 14'h040;
        resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", 32'(resp_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_drops_resp", 32'(resp_valid), 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        resp_ready = 1'b1;
        tick();
        req_expect("rd_crmd_after_rst", 3'd0, 14'h000, 32'h0, 32'h0, 32'h0000_0008);
        req_expect("rd_save0_after_rst", 3'd0, 14'h030, 32'h0, 32'h0, 32'h0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
